// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot-time loader that packs a little-endian byte stream into
// 32-bit instruction words and writes them to consecutive word indices 0..len-1
// of the instruction RAM while holding the core stalled.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, load_len     1-cycle load request and its word count (1..DEPTH)
//   rx_data, rx_valid   incoming byte stream
//   rx_ready            byte accepted this cycle when rx_valid is also high
//   we, waddr, wdata    instruction RAM write port (word addressed)
//   core_stall          1 = pipeline frozen with PC held at 0
//   busy, done, err     load in progress / program resident / illegal start pulse
module imem_boot_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              core_stall,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t              r_state, w_state_n;
  logic [1:0]          r_byte_cnt, w_byte_cnt_n;
  logic [ADDR_W-1:0]   r_word_idx, w_word_idx_n;
  logic [LEN_W-1:0]    r_len, w_len_n;
  logic [31:0]         r_pack, w_pack_n;
  logic [ADDR_W-1:0]   r_waddr, w_waddr_n;
  logic [31:0]         r_wdata, w_wdata_n;
  logic                r_we, r_rx_ready, r_busy, r_done, r_err, r_core_stall;
  logic                w_err_n;
  logic                w_start_ok;
  logic                w_xfer;
  logic                w_last;

  assign w_start_ok = start && (load_len != LEN_W'(0)) && (load_len <= LEN_W'(DEPTH));
  assign w_xfer     = rx_valid && (r_state == S_LOAD);
  assign w_last     = ({1'b0, r_word_idx} == (r_len - LEN_W'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  // Next-state, counter and datapath logic
  always_comb begin
    w_state_n    = r_state;
    w_byte_cnt_n = r_byte_cnt;
    w_word_idx_n = r_word_idx;
    w_len_n      = r_len;
    w_pack_n     = r_pack;
    w_waddr_n    = r_waddr;
    w_wdata_n    = r_wdata;
    w_err_n      = 1'b0;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (w_start_ok) begin
            w_state_n    = S_LOAD;
            w_len_n      = load_len;
            w_word_idx_n = '0;
            w_byte_cnt_n = '0;
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          unique case (r_byte_cnt)
            2'd0: w_pack_n[7:0]   = rx_data;
            2'd1: w_pack_n[15:8]  = rx_data;
            2'd2: w_pack_n[23:16] = rx_data;
            2'd3: w_pack_n[31:24] = rx_data;
            default: w_pack_n = r_pack;
          endcase
          if (r_byte_cnt == 2'd3) begin
            // Word complete: present it on the write port during WRITE
            w_byte_cnt_n = '0;
            w_state_n    = S_WRITE;
            w_waddr_n    = r_word_idx;
            w_wdata_n    = w_pack_n;
          end else begin
            w_byte_cnt_n = r_byte_cnt + 2'd1;
          end
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_state_n = S_DONE;
        end else begin
          w_word_idx_n = r_word_idx + ADDR_W'(1);
          w_state_n    = S_LOAD;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Counters and outputs, registered so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte_cnt   <= '0;
      r_word_idx   <= '0;
      r_len        <= '0;
      r_pack       <= '0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_rx_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_core_stall <= 1'b1;
    end else begin
      r_byte_cnt   <= w_byte_cnt_n;
      r_word_idx   <= w_word_idx_n;
      r_len        <= w_len_n;
      r_pack       <= w_pack_n;
      r_waddr      <= w_waddr_n;
      r_wdata      <= w_wdata_n;
      r_we         <= (w_state_n == S_WRITE);
      r_rx_ready   <= (w_state_n == S_LOAD);
      r_busy       <= (w_state_n == S_LOAD) || (w_state_n == S_WRITE);
      r_done       <= (w_state_n == S_DONE);
      r_err        <= w_err_n;
      r_core_stall <= (w_state_n != S_DONE);
    end
  end

  assign rx_ready   = r_rx_ready;
  assign we         = r_we;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign core_stall = r_core_stall;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
